// File: rtl/serial_byte_loader.sv
// serial_byte_loader: assembles MSB-first serial bits into a byte for the downstream `register` block.
// Latency: data/enable update on the edge that samples the last bit (parity bit when parity is enabled).
// Backpressure: none; bit_valid=0 cycles are stalls with unlimited gaps, and abort/start override bits.
//
// Ports:
//   clk, rst_            rising-edge clock, asynchronous active-low reset
//   start                one-cycle frame start (also restarts a frame in progress)
//   bit_valid, sdata     serial bit qualifier and bit, MSB first
//   abort                synchronous frame abort, highest priority
//   data [WIDTH-1:0]     last completed byte, held between loads
//   enable               one-cycle load strobe to the downstream register
//   busy                 high while a frame is in progress
//   perr                 one-cycle parity error strobe (only with SBL_PARITY_EN)
//
// Build option: define SBL_PARITY_EN for 9-bit frames with even parity
// and the perr port. Undefined: 8-bit frames, every frame loads.
module serial_byte_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             sdata,
  input  logic             abort,
  output logic [WIDTH-1:0] data,
  output logic             enable,
  output logic             busy
`ifdef SBL_PARITY_EN
  ,
  output logic             perr
`endif
);

`ifdef SBL_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_enable, w_enable_nxt;
  logic [WIDTH-1:0] w_byte;
`ifdef SBL_PARITY_EN
  logic             r_perr, w_perr_nxt;
  logic             w_par_ok;
`endif

  // Byte as it would look with the current bit shifted in.
  assign w_byte = {r_shreg[WIDTH-2:0], sdata};
`ifdef SBL_PARITY_EN
  // Even parity: the 8 data bits plus the parity bit XOR to zero.
  assign w_par_ok = ~(^{r_shreg, sdata});
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_enable <= 1'b0;
`ifdef SBL_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_enable <= w_enable_nxt;
`ifdef SBL_PARITY_EN
      r_perr   <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    w_enable_nxt = 1'b0;
`ifdef SBL_PARITY_EN
    w_perr_nxt   = 1'b0;
`endif
    if (abort) begin
      // Discard the partial frame; no strobes.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (start) begin
      // Start wins over a coinciding bit, including a frame's final bit.
      w_state_nxt = S_SHIFT;
      w_cnt_nxt   = '0;
    end else if (bit_valid) begin
      unique case (r_state)
        S_SHIFT: begin
          w_shreg_nxt = w_byte;
          // 3-bit counter wraps 7->0 exactly on the last data bit.
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == LAST_BIT) begin
`ifdef SBL_PARITY_EN
            w_state_nxt = S_PAR;
`else
            w_state_nxt  = S_IDLE;
            w_data_nxt   = w_byte;
            w_enable_nxt = 1'b1;
`endif
          end
        end
`ifdef SBL_PARITY_EN
        S_PAR: begin
          w_state_nxt = S_IDLE;
          if (w_par_ok) begin
            w_data_nxt   = r_shreg;
            w_enable_nxt = 1'b1;
          end else begin
            w_perr_nxt = 1'b1;
          end
        end
`endif
        default: ; // IDLE ignores bit_valid
      endcase
    end
  end

  assign data   = r_data;
  assign enable = r_enable;
  assign busy   = (r_state != S_IDLE);
`ifdef SBL_PARITY_EN
  assign perr   = r_perr;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       rst_;
  logic       start, bit_valid, sdata, abort;
  logic [7:0] data;
  logic       enable, busy;
  logic       perr_w;

  serial_byte_loader #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .bit_valid (bit_valid),
    .sdata     (sdata),
    .abort     (abort),
    .data      (data),
    .enable    (enable),
    .busy      (busy)
`ifdef SBL_PARITY_EN
    ,
    .perr      (perr_w)
`endif
  );
`ifndef SBL_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Downstream 8-bit register fed by data/enable.
  logic [7:0] reg_out;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) reg_out <= 8'h00;
    else if (enable) reg_out <= data;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one entry per expected strobe (load or parity error).
  typedef struct packed {
    logic       perr;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];
  logic [7:0] last_data = 8'h00;

  logic       pend_reg = 1'b0;
  logic [7:0] pend_val = 8'h00;

  always @(negedge clk) begin
    if (rst_) begin
      if (pend_reg) begin
        chk("downstream_reg", {24'h0, reg_out}, {24'h0, pend_val});
        pend_reg = 1'b0;
      end
      if (enable || perr_w) begin
        if (enable && perr_w) chk("enable_perr_exclusive", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: enable=%0b perr=%0b data=%0h, expected none at %0t",
                   enable, perr_w, data, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_kind_perr", {31'h0, perr_w}, {31'h0, e.perr});
          chk("strobe_data", {24'h0, data}, {24'h0, e.d});
          if (enable) begin
            pend_reg = 1'b1;
            pend_val = data;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start cycle also carries a junk bit that must not be captured.
  task automatic send_start();
    start = 1'b1; bit_valid = 1'b1; sdata = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1; sdata = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b, input int gapmax, input logic par,
                       input logic eperr, input logic [7:0] edata, input logic do_start);
    if (do_start) send_start();
    for (int i = 7; i >= 0; i--) begin
`ifndef SBL_PARITY_EN
      if (i == 0) sb.push_back({eperr, edata});
`endif
      send_bit(b[i]);
      if (i > 0) begin
        chk("busy_in_frame", {31'h0, busy}, 32'd1);
        repeat ($urandom_range(gapmax, 0)) begin
          tick();
          chk("busy_in_gap", {31'h0, busy}, 32'd1);
        end
      end
    end
`ifdef SBL_PARITY_EN
    chk("busy_before_parity", {31'h0, busy}, 32'd1);
    repeat ($urandom_range(gapmax, 0)) tick();
    sb.push_back({eperr, edata});
    send_bit(par);
`else
    if (par) ; // parity bit not transmitted in 8-bit framing
`endif
    chk("busy_after_frame", {31'h0, busy}, 32'd0);
    if (!eperr) last_data = edata;
  endtask

  typedef struct {
    logic [7:0] val;
    int         gapmax;
    logic       par;
    logic       exp_perr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h55, 3, 1'b0, 1'b0, 8'h55};
    tbl[1] = '{8'hC3, 0, 1'b0, 1'b0, 8'hC3};
`ifdef SBL_PARITY_EN
    tbl[2] = '{8'h0F, 1, 1'b1, 1'b1, 8'hC3};
`else
    tbl[2] = '{8'h0F, 1, 1'b1, 1'b0, 8'h0F};
`endif
    tbl[3] = '{8'h0F, 0, 1'b0, 1'b0, 8'h0F};
    tbl[4] = '{8'hFF, 2, 1'b0, 1'b0, 8'hFF};
    tbl[5] = '{8'h00, 1, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{8'h55, 3, 1'b0, 1'b0, 8'h55};

    rst_ = 1'b0; start = 1'b0; bit_valid = 1'b0; sdata = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", {24'h0, data}, 32'h0);
    chk("reset_enable", {31'h0, enable}, 32'd0);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_perr", {31'h0, perr_w}, 32'd0);
    rst_ = 1'b1;

    // bit_valid while idle changes nothing.
    for (int i = 0; i < 4; i++) begin
      send_bit(i[0]);
      chk("idle_busy", {31'h0, busy}, 32'd0);
      chk("idle_data", {24'h0, data}, 32'h0);
    end

    // Contiguous AA frame, then data must hold.
    frame(8'hAA, 0, 1'b0, 1'b0, 8'hAA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", {24'h0, data}, 32'hAA);
      tick();
    end

    // Table frames, issued back-to-back (start lands in the enable cycle).
    for (int k = 0; k < 7; k++)
      frame(tbl[k].val, tbl[k].gapmax, tbl[k].par, tbl[k].exp_perr, tbl[k].exp_data, 1'b1);
    tick();
    chk("after_table_data", {24'h0, data}, {24'h0, last_data});

    // Abort after 5 bits.
    send_start();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    repeat (2) tick();
    chk("abort_data_kept", {24'h0, data}, {24'h0, last_data});

    // Restart after 4 bits, then full C3 frame.
    send_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    frame(8'hC3, 0, 1'b0, 1'b0, 8'hC3, 1'b1);
    tick();
    chk("restart_data", {24'h0, data}, 32'hC3);

    // Start coinciding with the final bit: nothing loads, new frame begins.
    send_start();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
`ifdef SBL_PARITY_EN
    send_bit(1'b0);
`endif
    start = 1'b1; bit_valid = 1'b1; sdata = 1'b0;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    chk("start_on_last_busy", {31'h0, busy}, 32'd1);
    chk("start_on_last_data", {24'h0, data}, 32'hC3);
    frame(8'h3C, 1, 1'b0, 1'b0, 8'h3C, 1'b0);
    tick();

    // Asynchronous reset mid-frame.
    send_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    chk("async_rst_data", {24'h0, data}, 32'h0);
    chk("async_rst_busy", {31'h0, busy}, 32'd0);
    chk("async_rst_enable", {31'h0, enable}, 32'd0);
    chk("async_rst_reg", {24'h0, reg_out}, 32'h0);
    last_data = 8'h00;
    @(posedge clk);
    #3;
    rst_ = 1'b1;
    tick();
    frame(8'h81, 0, 1'b0, 1'b0, 8'h81, 1'b1);
    repeat (3) tick();
    chk("final_data", {24'h0, data}, 32'h81);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
